hd_bitserial_sub_decoder: RTL and testbench
===========================================

Name: hd_bitserial_sub_decoder

Overview:
- Decoder-side companion to the combinational 8-bit two-operand arithmetic benchmarks.
- Accepts an encoded word s and one original operand a, then recovers the other operand as b = (s - a) mod 2^W.
- Works bit-serially, LSB first, one bit per clock, so it serves as a small sequential benchmark that round-trips the adder-style encoders.
- Input and output both use valid/ready handshakes.

Parameters:
- W, 8, operand and result width in bits; legal range is W >= 2.
- CW, $clog2(W), bit-counter width; derived, not user-overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents s/a.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  W  encoded word s.
- in_a  input  W  known operand a.
- out_valid  output  1  result is valid.
- out_ready  input  1  sink accepts the result.
- out_b  output  W  recovered operand (s - a) mod 2^W.
- out_borrow  output  1  final borrow; 1 iff a > s as unsigned values.
- out_zero  output  1  1 iff out_b == 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst is high: state=IDLE, in_ready=1, out_valid=0, out_b=0, out_borrow=0, out_zero=0.
  - Shift registers, borrow and counter are all 0.
  - Reset asserted mid-operation aborts any in-flight pair with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_sum->sreg and in_a->areg, set br=0 and cnt=0, go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored and nothing is latched.
  - Each edge:
    - d = sreg[0]^areg[0]^br.
    - br <= (~sreg[0]&areg[0]) | (~(sreg[0]^areg[0])&br).
    - res <= {d, res[W-1:1]}.
    - sreg and areg shift right by 1, zero fill.
    - cnt <= cnt+1.
  - On the edge where cnt==W-1, the last bit is processed and the state goes to DONE. In the same edge: out_b <= final res, out_borrow <= final br, out_zero <= (final res==0).
- DONE:
  - out_valid=1; out_b, out_borrow and out_zero are held stable.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - out_ready=0 holds DONE indefinitely.
  - No new pair is accepted in DONE, even when out_ready=1 in the same cycle.
- Latency: out_valid rises exactly W edges after the accepting edge.
- Throughput: at most one pair per W+2 cycles with out_ready tied high.
- Outputs are registered (Moore); there is no combinational path from in_* to out_*.
- Arithmetic is unsigned modulo 2^W; out_borrow reports wrap-around.
- cnt never exceeds W-1; no wrap of cnt is permitted.

Decomposition:
- Shared package hd_serial_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Function clog2w for CW.
  - Localparam for the default W.
- One sub-module: hd_fsub_cell, a combinational 1-bit full subtractor.
  - Inputs: s, a, bin. Outputs: d, bout.
  - The top instantiates it once on the serial datapath.

Test Plan:
- W=8, s=8'h05, a=8'h03, out_ready=1 -> out_valid 8 edges after accept; out_b=8'h02, borrow=0, zero=0.
- W=8, s=8'h03, a=8'h05 -> out_b=8'hFE, borrow=1, zero=0.
- W=8, s=a=8'hA5 -> out_b=8'h00, borrow=0, zero=1.
- W=8, s=8'h80, a=8'h01, out_ready low for 5 cycles after out_valid -> out_b=8'h7F held stable and in_ready=0 throughout; then one cycle of out_ready -> IDLE, in_ready=1.
- W=8, accept s=8'hFF, a=8'h0F; toggle in_valid with other data during SHIFT; assert rst async at SHIFT cycle 4 -> immediate IDLE, out_valid=0, all outputs 0. A following pair s=8'h10, a=8'h01 yields out_b=8'h0F, borrow=0.
- W=16, s=16'h0000, a=16'h0001 -> out_valid after 16 edges; out_b=16'hFFFF, borrow=1, zero=0.

Source files
------------

// File: rtl/hd_serial_pkg.sv
// Shared types and helpers for the bit-serial decoder benchmarks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hd_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

  // Bits needed to count 0..w-1; at least one bit so a counter always exists.
  function automatic int clog2w(input int w);
    int n;
    n = 1;
    while ((1 << n) < w) n++;
    return n;
  endfunction

endpackage

// File: rtl/hd_fsub_cell.sv
// One-bit full subtractor: d = s - a - bin, with borrow out.
// Latency: combinational.
// Backpressure: not applicable.
module hd_fsub_cell (
  input  logic s,
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when a exceeds s, or they match and a borrow ripples in.
  always_comb begin
    d    = s ^ a ^ bin;
    bout = (~s & a) | (~(s ^ a) & bin);
  end

endmodule

// File: rtl/hd_bitserial_sub_decoder.sv
// Recovers b = (s - a) mod 2^W bit-serially, LSB first, one bit per clock.
// Latency: out_valid rises W edges after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module hd_bitserial_sub_decoder
  import hd_serial_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_b,
  output logic         out_borrow,
  output logic         out_zero
);

  localparam int CW = clog2w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   sreg;
  logic [W-1:0]   areg;
  logic [W-1:0]   res;
  logic [W-1:0]   res_nxt;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           d_bit;
  logic           b_out;

  hd_fsub_cell u_cell (
    .s    (sreg[0]),
    .a    (areg[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (b_out)
  );

  // Result bits enter at the MSB so after W shifts bit 0 lands at res[0].
  assign res_nxt = {d_bit, res[W-1:1]};

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept in IDLE, run W bit steps, wait for the sink in DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)    state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Serial datapath: load operands, shift one bit per edge, publish on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg       <= '0;
      areg       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      out_b      <= '0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= in_sum;
            areg <= in_a;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          br   <= b_out;
          res  <= res_nxt;
          sreg <= sreg >> 1;
          areg <= areg >> 1;
          if (cnt == LAST) begin
            // Counter parks at W-1 rather than wrapping.
            out_b      <= res_nxt;
            out_borrow <= b_out;
            out_zero   <= (res_nxt == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_bitserial_sub_decoder.sv
module tb_hd_bitserial_sub_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=8 instance
  logic       v8, r8, ov8, or8, bor8, z8;
  logic [7:0] s8, a8, b8;
  // W=16 instance
  logic        v16, r16, ov16, or16, bor16, z16;
  logic [15:0] s16, a16, b16;

  hd_bitserial_sub_decoder #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_sum(s8), .in_a(a8),
    .out_valid(ov8), .out_ready(or8), .out_b(b8), .out_borrow(bor8), .out_zero(z8)
  );

  hd_bitserial_sub_decoder #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_sum(s16), .in_a(a16),
    .out_valid(ov16), .out_ready(or16), .out_b(b16), .out_borrow(bor16), .out_zero(z16)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic       bor;
    logic       z;
    int         hold;
    bit         early;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole word.
  function automatic logic [9:0] model8(input logic [7:0] s, input logic [7:0] a);
    logic [7:0] b;
    b = s - a;
    return {b, (a > s), (b == 8'h00)};
  endfunction

  // One W=8 transaction starting from IDLE, 1 time unit after a rising edge.
  task automatic run8(input logic [7:0] s, input logic [7:0] a, input logic [7:0] eb,
                      input logic ebor, input logic ez, input int hold, input bit early);
    int lat;
    chk("in_ready_idle", r8, 1);
    s8 = s; a8 = a; v8 = 1'b1; or8 = early;
    @(posedge clk); #1;
    v8 = 1'b0;
    chk("in_ready_shift", r8, 0);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 8);
    chk("out_b", b8, eb);
    chk("out_borrow", bor8, ebor);
    chk("out_zero", z8, ez);
    if (!early) begin
      // Offer a different pair while parked in DONE; it must not be taken.
      v8 = 1'b1; s8 = ~s; a8 = ~a;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_out_b", b8, eb);
        chk("hold_valid", ov8, 1);
        chk("hold_in_ready", r8, 0);
      end
      or8 = 1'b1;
    end
    @(posedge clk); #1;
    chk("release_in_ready", r8, 1);
    chk("release_valid", ov8, 0);
    v8 = 1'b0; or8 = 1'b0;
  endtask

  task automatic run16(input logic [15:0] s, input logic [15:0] a);
    int lat;
    logic [15:0] eb;
    eb = s - a;
    s16 = s; a16 = a; v16 = 1'b1; or16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency16", lat, 16);
    chk("out_b16", b16, eb);
    chk("out_borrow16", bor16, (a > s));
    chk("out_zero16", z16, (eb == 16'h0000));
    @(posedge clk); #1;
    chk("release16_in_ready", r16, 1);
    or16 = 1'b0;
  endtask

  initial begin
    logic [7:0] rs, ra;
    logic [9:0] m;
    v8 = 0; or8 = 0; s8 = 0; a8 = 0;
    v16 = 0; or16 = 0; s16 = 0; a16 = 0;

    #1;
    chk("rst_in_ready", r8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_out_b", b8, 0);
    chk("rst_borrow", bor8, 0);
    chk("rst_zero", z8, 0);
    chk("rst16_in_ready", r16, 1);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 1'b1});
    vecs.push_back('{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 1'b1});
    vecs.push_back('{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 0, 1'b1});
    vecs.push_back('{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 5, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2, 1'b1});
    foreach (vecs[i])
      run8(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].bor, vecs[i].z, vecs[i].hold, vecs[i].early);

    // Async reset in the middle of a SHIFT phase, with in_valid toggling meanwhile.
    s8 = 8'hFF; a8 = 8'h0F; v8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      v8 = ~v8; s8 = 8'($urandom); a8 = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("mid_shift_in_ready", r8, 0);
    @(posedge clk); #3;
    rst = 1'b1; v8 = 1'b0;
    #1;
    chk("abort_in_ready", r8, 1);
    chk("abort_out_valid", ov8, 0);
    chk("abort_out_b", b8, 0);
    chk("abort_borrow", bor8, 0);
    chk("abort_zero", z8, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("after_abort_valid", ov8, 0);
    run8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 2, 1'b0);

    // Randomized pairs against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rs = 8'($urandom); ra = 8'($urandom);
      if (i % 8 == 0) ra = rs;
      m = model8(rs, ra);
      run8(rs, ra, m[9:2], m[1], m[0], int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    // Wider instance.
    run16(16'h0000, 16'h0001);
    run16(16'h1234, 16'h1234);
    for (int i = 0; i < 6; i++) run16(16'($urandom), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
